cfg_bus_master: RTL

Configuration-bus initiator for CGRA tiles. It accepts one host request at a time over a valid/ready handshake and turns it into a config-bus write or read. Register-space requests drive config_en; SRAM-space requests drive a one-hot config_en_sram bank enable and gate the tile clock_enable around the access. Read data is returned to the host as a one-cycle response pulse. The tile memory cores sit on the far side of this bus.

---
 rtl/cfg_bus_master.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/cfg_bus_master.sv
// cfg_bus_master
//   Configuration-bus initiator for CGRA tiles. Accepts one host request at a
//   time (valid/ready) and issues a single config-bus write or read.
//   Register space (addr[31:24]==0) pulses config_en; SRAM space pulses a
//   one-hot config_en_sram bank enable (bank = addr[23:22]) and holds
//   tile_clk_en low for GATE_CYC cycles before and after the access.
//   Reads return config_rd_data on a one-cycle resp_valid pulse.
//
// Ports
//   clk_in, reset          clock, asynchronous active-high reset
//   req_valid/req_ready    host request handshake
//   req_write/addr/data    host request fields
//   resp_valid/resp_data   read response pulse / last captured read data
//   config_addr/data       tile address / write data
//   config_en              register-space enable pulse
//   config_en_sram         one-hot SRAM bank enable pulse
//   config_write/read      access strobes
//   config_rd_data         tile readback
//   tile_clk_en            tile clock enable
module cfg_bus_master #(
   parameter int unsigned GATE_CYC = 2,
   parameter int unsigned READ_LAT = 1
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_data,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic [31:0] config_addr,
   output logic [31:0] config_data,
   output logic        config_en,
   output logic [3:0]  config_en_sram,
   output logic        config_write,
   output logic        config_read,
   input  logic [31:0] config_rd_data,
   output logic        tile_clk_en
);

   localparam int unsigned CNT_MAX = (GATE_CYC > READ_LAT) ? GATE_CYC : READ_LAT;
   localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] GATE_LAST = CW'(GATE_CYC - 1);
   localparam logic [CW-1:0] RD_LAST   = CW'(READ_LAT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GATE_PRE,
      ST_ISSUE,
      ST_WAIT_RD,
      ST_GATE_POST
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   addr_q;
   logic [31:0]   data_q;
   logic          write_q;
   logic          sram_q;
   logic [31:0]   resp_data_q;

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         write_q     <= 1'b0;
         sram_q      <= 1'b0;
         resp_data_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == ST_IDLE && req_valid) begin
            addr_q  <= req_addr;
            data_q  <= req_data;
            write_q <= req_write;
            sram_q  <= (req_addr[31:24] != 8'h00);
         end
         if (resp_valid) begin
            resp_data_q <= config_rd_data;
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      req_ready      = 1'b0;
      resp_valid     = 1'b0;
      config_addr    = '0;
      config_data    = '0;
      config_en      = 1'b0;
      config_en_sram = '0;
      config_write   = 1'b0;
      config_read    = 1'b0;
      tile_clk_en    = 1'b1;
      unique case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               cnt_d   = '0;
               state_d = (req_addr[31:24] != 8'h00) ? ST_GATE_PRE : ST_ISSUE;
            end
         end
         ST_GATE_PRE: begin
            tile_clk_en = 1'b0;
            if (cnt_q == GATE_LAST) begin
               cnt_d   = '0;
               state_d = ST_ISSUE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_ISSUE: begin
            tile_clk_en    = !sram_q;
            config_addr    = addr_q;
            config_data    = data_q;
            config_write   = write_q;
            config_read    = !write_q;
            config_en      = !sram_q;
            config_en_sram = sram_q ? 4'(4'b0001 << addr_q[23:22]) : 4'b0000;
            cnt_d          = '0;
            if (!write_q) begin
               state_d = ST_WAIT_RD;
            end else if (sram_q) begin
               state_d = ST_GATE_POST;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT_RD: begin
            tile_clk_en = !sram_q;
            config_addr = addr_q;
            config_read = 1'b1;
            if (cnt_q == RD_LAST) begin
               resp_valid = 1'b1;
               cnt_d      = '0;
               state_d    = sram_q ? ST_GATE_POST : ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_GATE_POST: begin
            tile_clk_en = 1'b0;
            if (cnt_q == GATE_LAST) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Tile data is valid in the pulse cycle itself, so it is passed straight
   // through then and held from the register afterwards.
   assign resp_data = resp_valid ? config_rd_data : resp_data_q;

endmodule
